discriminant_calculator: RTL and testbench



---
 rtl/raytrace_pkg.sv | 31 +++
 rtl/dot3.sv | 28 ++
 rtl/discriminant_calculator.sv | 130 +++++++++++++
 tb/tb_discriminant_calculator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/raytrace_pkg.sv
// Shared types and widths for the ray/sphere discriminant datapath.
// Widths grow at each stage so that no intermediate value wraps.
package raytrace_pkg;

   localparam int W  = 16;
   localparam int LW = W + 1;
   localparam int PW = 2 * W + 2;
   localparam int SW = 2 * W + 4;
   localparam int DW = 4 * W + 12;

   typedef struct packed {
      logic signed [W-1:0] x;
      logic signed [W-1:0] y;
      logic signed [W-1:0] z;
   } vec3_t;

   typedef struct packed {
      logic signed [LW-1:0] x;
      logic signed [LW-1:0] y;
      logic signed [LW-1:0] z;
   } lvec3_t;

   typedef enum logic [2:0] {
      IDLE,
      DIFF,
      DOTS,
      DISC,
      OUT
   } state_t;

endpackage

// File: rtl/dot3.sv
// Combinational signed three-element dot product.
// The result is full precision as long as OW >= 2*IW + 2.
module dot3 #(
   parameter int IW = 17,
   parameter int OW = 36
) (
   input  logic signed [IW-1:0] a_x,
   input  logic signed [IW-1:0] a_y,
   input  logic signed [IW-1:0] a_z,
   input  logic signed [IW-1:0] b_x,
   input  logic signed [IW-1:0] b_y,
   input  logic signed [IW-1:0] b_z,
   output logic signed [OW-1:0] result
);

   logic signed [OW-1:0] ax, ay, az, bx, by, bz;

   // Sign-extend before multiplying so each product is computed at full width.
   assign ax = {{(OW-IW){a_x[IW-1]}}, a_x};
   assign ay = {{(OW-IW){a_y[IW-1]}}, a_y};
   assign az = {{(OW-IW){a_z[IW-1]}}, a_z};
   assign bx = {{(OW-IW){b_x[IW-1]}}, b_x};
   assign by = {{(OW-IW){b_y[IW-1]}}, b_y};
   assign bz = {{(OW-IW){b_z[IW-1]}}, b_z};

   assign result = ax * bx + ay * by + az * bz;

endmodule

// File: rtl/discriminant_calculator.sv
// Multi-cycle ray/sphere pre-test: returns B, the discriminant B^2-4AC
// (low W bits) and a hit flag taken from the full-precision sign.
module discriminant_calculator
   import raytrace_pkg::*;
(
   input  logic         CLK,
   input  logic         aresetn,
   input  logic [W-1:0] SphereX,
   input  logic [W-1:0] SphereY,
   input  logic [W-1:0] SphereZ,
   input  logic [W-1:0] SphereRadius,
   input  logic [W-1:0] RayStartX,
   input  logic [W-1:0] RayStartY,
   input  logic [W-1:0] RayStartZ,
   input  logic [W-1:0] RayDirX,
   input  logic [W-1:0] RayDirY,
   input  logic [W-1:0] RayDirZ,
   input  logic         InputValid,
   output logic         InputReady,
   output logic         QuickIntersects,
   output logic [W-1:0] Discriminant,
   output logic [W-1:0] B_out,
   output logic         OutputReady
);

   state_t state, next_state;

   vec3_t               sphere_q, start_q, dir_q;
   logic signed [W-1:0] radius_q;
   lvec3_t              l_q, d_ext;
   logic signed [SW-1:0] a_q, dl_q, c_q;
   logic signed [SW-1:0] dd_dot, dl_dot, ll_dot, rr;
   logic signed [DW-1:0] a_full, b_full, c_full, disc_full;

   always_ff @(posedge CLK or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (InputValid) next_state = DIFF;
         DIFF:    next_state = DOTS;
         DOTS:    next_state = DISC;
         DISC:    next_state = OUT;
         OUT:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      InputReady  = (state == IDLE);
      OutputReady = (state == OUT);
   end

   assign d_ext.x = {dir_q.x[W-1], dir_q.x};
   assign d_ext.y = {dir_q.y[W-1], dir_q.y};
   assign d_ext.z = {dir_q.z[W-1], dir_q.z};

   dot3 #(.IW(LW), .OW(SW)) u_dd (
      .a_x(d_ext.x), .a_y(d_ext.y), .a_z(d_ext.z),
      .b_x(d_ext.x), .b_y(d_ext.y), .b_z(d_ext.z),
      .result(dd_dot)
   );

   dot3 #(.IW(LW), .OW(SW)) u_dl (
      .a_x(d_ext.x), .a_y(d_ext.y), .a_z(d_ext.z),
      .b_x(l_q.x),   .b_y(l_q.y),   .b_z(l_q.z),
      .result(dl_dot)
   );

   dot3 #(.IW(LW), .OW(SW)) u_ll (
      .a_x(l_q.x), .a_y(l_q.y), .a_z(l_q.z),
      .b_x(l_q.x), .b_y(l_q.y), .b_z(l_q.z),
      .result(ll_dot)
   );

   assign rr = SW'(radius_q) * SW'(radius_q);

   // B is 2*(D.L), so the doubling is folded into the final-stage shift.
   assign a_full    = DW'(a_q);
   assign b_full    = DW'(dl_q) <<< 1;
   assign c_full    = DW'(c_q);
   assign disc_full = b_full * b_full - ((a_full * c_full) <<< 2);

   always_ff @(posedge CLK or negedge aresetn) begin
      if (!aresetn) begin
         sphere_q        <= '0;
         start_q         <= '0;
         dir_q           <= '0;
         radius_q        <= '0;
         l_q             <= '0;
         a_q             <= '0;
         dl_q            <= '0;
         c_q             <= '0;
         QuickIntersects <= 1'b0;
         Discriminant    <= '0;
         B_out           <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (InputValid) begin
                  sphere_q <= '{x: SphereX, y: SphereY, z: SphereZ};
                  start_q  <= '{x: RayStartX, y: RayStartY, z: RayStartZ};
                  dir_q    <= '{x: RayDirX, y: RayDirY, z: RayDirZ};
                  radius_q <= SphereRadius;
               end
            end
            DIFF: begin
               l_q.x <= {start_q.x[W-1], start_q.x} - {sphere_q.x[W-1], sphere_q.x};
               l_q.y <= {start_q.y[W-1], start_q.y} - {sphere_q.y[W-1], sphere_q.y};
               l_q.z <= {start_q.z[W-1], start_q.z} - {sphere_q.z[W-1], sphere_q.z};
            end
            DOTS: begin
               a_q  <= dd_dot;
               dl_q <= dl_dot;
               c_q  <= ll_dot - rr;
            end
            DISC: begin
               B_out           <= b_full[W-1:0];
               Discriminant    <= disc_full[W-1:0];
               QuickIntersects <= ~disc_full[DW-1];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_discriminant_calculator.sv
// Self-checking bench: directed geometry cases, randomized operands against a
// wide-integer model of B^2-4AC, busy-time InputValid and reset abort.
module tb_discriminant_calculator;

   logic        CLK;
   logic        aresetn;
   logic [15:0] sph [3];
   logic [15:0] org [3];
   logic [15:0] dir [3];
   logic [15:0] rad;
   logic        InputValid;
   logic        InputReady;
   logic        QuickIntersects;
   logic [15:0] Discriminant;
   logic [15:0] B_out;
   logic        OutputReady;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_b;
   logic [15:0] exp_d;
   logic        exp_hit;

   discriminant_calculator dut (
      .CLK(CLK),
      .aresetn(aresetn),
      .SphereX(sph[0]),
      .SphereY(sph[1]),
      .SphereZ(sph[2]),
      .SphereRadius(rad),
      .RayStartX(org[0]),
      .RayStartY(org[1]),
      .RayStartZ(org[2]),
      .RayDirX(dir[0]),
      .RayDirY(dir[1]),
      .RayDirZ(dir[2]),
      .InputValid(InputValid),
      .InputReady(InputReady),
      .QuickIntersects(QuickIntersects),
      .Discriminant(Discriminant),
      .B_out(B_out),
      .OutputReady(OutputReady)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference: ray/sphere quadratic evaluated in 128-bit signed integers.
   task automatic compute_model();
      logic signed [127:0] a, dl, c, l, d, b, disc, r;
      a  = 0;
      dl = 0;
      c  = 0;
      for (int k = 0; k < 3; k++) begin
         l  = $signed(org[k]);
         l  = l - $signed(sph[k]);
         d  = $signed(dir[k]);
         a  = a + d * d;
         dl = dl + d * l;
         c  = c + l * l;
      end
      r    = $signed(rad);
      c    = c - r * r;
      b    = 2 * dl;
      disc = b * b - 4 * a * c;
      exp_b   = b[15:0];
      exp_d   = disc[15:0];
      exp_hit = (disc >= 0);
   endtask

   task automatic set_ops(input int sx, input int sy, input int sz, input int r,
                          input int ox, input int oy, input int oz,
                          input int dx, input int dy, input int dz);
      sph[0] = 16'(sx); sph[1] = 16'(sy); sph[2] = 16'(sz); rad = 16'(r);
      org[0] = 16'(ox); org[1] = 16'(oy); org[2] = 16'(oz);
      dir[0] = 16'(dx); dir[1] = 16'(dy); dir[2] = 16'(dz);
   endtask

   task automatic scramble_ops();
      for (int k = 0; k < 3; k++) begin
         sph[k] = 16'($urandom);
         org[k] = 16'($urandom);
         dir[k] = 16'($urandom);
      end
      rad = 16'($urandom);
   endtask

   // Issues the current operands and follows the transaction for 8 cycles.
   task automatic run_op(input string name, input bit inject_busy);
      compute_model();
      @(negedge CLK);
      n_checks++;
      if (InputReady !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL %s ready_before: InputReady=%b required 1", name, InputReady);
      end
      InputValid = 1'b1;
      @(posedge CLK);
      #1;
      InputValid = 1'b0;
      scramble_ops();
      for (int i = 1; i <= 8; i++) begin
         @(negedge CLK);
         n_checks++;
         if (OutputReady !== (i == 4)) begin
            n_fail++;
            $display("[TB] FAIL %s strobe cycle %0d: OutputReady=%b required %b",
                     name, i, OutputReady, (i == 4));
         end
         if (i == 4 || i == 8) begin
            n_checks++;
            if (B_out !== exp_b || Discriminant !== exp_d || QuickIntersects !== exp_hit) begin
               n_fail++;
               $display("[TB] FAIL %s result cycle %0d: B=%0d D=%0d hit=%b required B=%0d D=%0d hit=%b",
                        name, i, $signed(B_out), $signed(Discriminant), QuickIntersects,
                        $signed(exp_b), $signed(exp_d), exp_hit);
            end
         end
         if (i == 5) begin
            n_checks++;
            if (InputReady !== 1'b1) begin
               n_fail++;
               $display("[TB] FAIL %s ready_after: InputReady=%b required 1", name, InputReady);
            end
         end else if (i < 4) begin
            n_checks++;
            if (InputReady !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL %s busy cycle %0d: InputReady=%b required 0", name, i, InputReady);
            end
         end
         if (inject_busy && i == 2) InputValid = 1'b1;
         if (inject_busy && i == 3) InputValid = 1'b0;
      end
   endtask

   task automatic test_reset();
      aresetn    = 1'b0;
      InputValid = 1'b0;
      set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge CLK);
      aresetn = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (InputReady !== 1'b1 || OutputReady !== 1'b0 || QuickIntersects !== 1'b0 ||
          Discriminant !== 16'd0 || B_out !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_state: rdy=%b ord=%b hit=%b D=%h B=%h required 1 0 0 0000 0000",
                  InputReady, OutputReady, QuickIntersects, Discriminant, B_out);
      end
   endtask

   task automatic test_directed();
      set_ops(0, 0, 0, 2, 0, 10, 0, 0, -1, 0);
      run_op("hit", 1'b0);
      n_checks++;
      if (exp_b !== 16'hFFEC || exp_d !== 16'd16 || exp_hit !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL model_hit: B=%0d D=%0d required -20 16", $signed(exp_b), $signed(exp_d));
      end
      set_ops(10, -10, 10, 2, 0, 10, 0, 0, -1, 0);
      run_op("miss", 1'b0);
      set_ops(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      run_op("tangent", 1'b0);
      set_ops(0, 0, 0, 100, 200, 0, 0, 1, 0, 0);
      run_op("truncation", 1'b0);
      n_checks++;
      if (Discriminant !== 16'(-25536) || B_out !== 16'd400 || QuickIntersects !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL truncation_literal: D=%0d B=%0d hit=%b required -25536 400 1",
                  $signed(Discriminant), $signed(B_out), QuickIntersects);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         if (n % 2 == 0) begin
            scramble_ops();
            rad = 16'($urandom_range(0, 32767));
         end else begin
            for (int k = 0; k < 3; k++) begin
               sph[k] = 16'(int'($urandom_range(0, 100)) - 50);
               org[k] = 16'(int'($urandom_range(0, 100)) - 50);
               dir[k] = 16'(int'($urandom_range(0, 20)) - 10);
            end
            rad = 16'($urandom_range(0, 60));
         end
         run_op("random", 1'b0);
      end
   endtask

   task automatic test_busy_ignore();
      set_ops(0, 0, 0, 2, 0, 10, 0, 0, -1, 0);
      run_op("busy_ignore", 1'b1);
   endtask

   task automatic test_back_to_back();
      set_ops(5, 5, 5, 3, 0, 0, 0, 1, 1, 1);
      run_op("b2b_first", 1'b0);
      set_ops(-3, 7, 1, 9, 4, -2, 8, -1, 2, -3);
      run_op("b2b_second", 1'b0);
   endtask

   task automatic test_reset_abort();
      set_ops(0, 0, 0, 100, 200, 0, 0, 1, 0, 0);
      @(negedge CLK);
      InputValid = 1'b1;
      @(posedge CLK);
      #1;
      InputValid = 1'b0;
      repeat (2) @(negedge CLK);
      aresetn = 1'b0;
      #1;
      n_checks++;
      if (OutputReady !== 1'b0 || Discriminant !== 16'd0 || B_out !== 16'd0 ||
          QuickIntersects !== 1'b0 || InputReady !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL abort_clear: ord=%b D=%h B=%h hit=%b rdy=%b required 0 0000 0000 0 1",
                  OutputReady, Discriminant, B_out, QuickIntersects, InputReady);
      end
      @(negedge CLK);
      aresetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         n_checks++;
         if (OutputReady !== 1'b0 || InputReady !== 1'b1 || Discriminant !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL abort_after cycle %0d: ord=%b rdy=%b D=%h required 0 1 0000",
                     i, OutputReady, InputReady, Discriminant);
         end
      end
      set_ops(10, -10, 10, 2, 0, 10, 0, 0, -1, 0);
      run_op("after_abort", 1'b0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_busy_ignore();
      test_back_to_back();
      test_random();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
